// File: rtl/if_id_skid_stage.sv
// IF/ID stage with a main entry and one skid entry; a word accepted at edge N is on the outputs after N.
// in_ready is registered (!skid valid), so back-pressure from decode never reaches fetch combinationally.
module if_id_skid_stage #(
  parameter int              INSTR_W  = 32,
  parameter int              PC_W     = 32,
  parameter int              KBIT     = 31,
  parameter logic [PC_W-1:0] RESET_PC = 32'h80000004
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc4_in,
  input  logic               kernel_in,
  input  logic               irq,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc4_out,
  output logic               flushed_out
);

  logic               main_vld_q, main_vld_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    main_pc4_q, main_pc4_d;
  logic               main_flushed_q, main_flushed_d;

  // The skid only ever holds non-flush captures, so its flushed marker is always 0.
  logic               skid_vld_q, skid_vld_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc4_q, skid_pc4_d;

  logic               irq_pend_q, irq_pend_d;

  logic               accept;
  logic               drain;
  logic [PC_W-1:0]    cap_pc4;

  assign in_ready    = ~skid_vld_q;
  assign out_valid   = main_vld_q;
  assign instr_out   = main_instr_q;
  assign pc4_out     = main_pc4_q;
  assign flushed_out = main_flushed_q;

  assign accept = in_valid & in_ready;
  assign drain  = main_vld_q & out_ready;

  always_comb begin
    cap_pc4 = pc4_in;
    // A taken interrupt redirects into kernel space unless already there.
    if (!kernel_in && (irq || irq_pend_q)) begin
      cap_pc4[KBIT] = 1'b1;
    end
  end

  always_comb begin
    irq_pend_d = irq_pend_q;
    if (accept || kernel_in) begin
      irq_pend_d = 1'b0;
    end else if (irq) begin
      irq_pend_d = 1'b1;
    end
  end

  always_comb begin
    main_vld_d     = main_vld_q;
    main_instr_d   = main_instr_q;
    main_pc4_d     = main_pc4_q;
    main_flushed_d = main_flushed_q;
    skid_vld_d     = skid_vld_q;
    skid_instr_d   = skid_instr_q;
    skid_pc4_d     = skid_pc4_q;

    if (flush) begin
      skid_vld_d = 1'b0;
      if (accept) begin
        // Bubble keeps the PC so decode can still report an exception return address.
        main_vld_d     = 1'b1;
        main_instr_d   = '0;
        main_pc4_d     = cap_pc4;
        main_flushed_d = 1'b1;
      end else begin
        main_vld_d     = 1'b0;
        main_flushed_d = 1'b0;
      end
    end else if (!main_vld_q) begin
      if (accept) begin
        main_vld_d     = 1'b1;
        main_instr_d   = instr_in;
        main_pc4_d     = cap_pc4;
        main_flushed_d = 1'b0;
      end
    end else if (drain) begin
      if (skid_vld_q) begin
        main_vld_d     = 1'b1;
        main_instr_d   = skid_instr_q;
        main_pc4_d     = skid_pc4_q;
        main_flushed_d = 1'b0;
        skid_vld_d     = 1'b0;
      end else if (accept) begin
        main_vld_d     = 1'b1;
        main_instr_d   = instr_in;
        main_pc4_d     = cap_pc4;
        main_flushed_d = 1'b0;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_vld_d   = 1'b1;
      skid_instr_d = instr_in;
      skid_pc4_d   = cap_pc4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_vld_q     <= 1'b0;
      main_instr_q   <= '0;
      main_pc4_q     <= RESET_PC;
      main_flushed_q <= 1'b0;
      skid_vld_q     <= 1'b0;
      skid_instr_q   <= '0;
      skid_pc4_q     <= '0;
      irq_pend_q     <= 1'b0;
    end else begin
      main_vld_q     <= main_vld_d;
      main_instr_q   <= main_instr_d;
      main_pc4_q     <= main_pc4_d;
      main_flushed_q <= main_flushed_d;
      skid_vld_q     <= skid_vld_d;
      skid_instr_q   <= skid_instr_d;
      skid_pc4_q     <= skid_pc4_d;
      irq_pend_q     <= irq_pend_d;
    end
  end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage with hand-computed expectations.
module tb_if_id_skid_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr_in;
  logic [31:0] pc4_in;
  logic        kernel_in;
  logic        irq;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_out;
  logic [31:0] pc4_out;
  logic        flushed_out;

  int n_checks;
  int n_pass;

  if_id_skid_stage #(
    .INSTR_W (32),
    .PC_W    (32),
    .KBIT    (31),
    .RESET_PC(32'h80000004)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr_in   (instr_in),
    .pc4_in     (pc4_in),
    .kernel_in  (kernel_in),
    .irq        (irq),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr_out  (instr_out),
    .pc4_out    (pc4_out),
    .flushed_out(flushed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid = v;
    instr_in = ins;
    pc4_in   = pc;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic fl);
    chk({tag, ".ov"}, 32'(out_valid), 32'(v));
    chk({tag, ".instr"}, instr_out, ins);
    chk({tag, ".pc4"}, pc4_out, pc);
    chk({tag, ".fl"}, 32'(flushed_out), 32'(fl));
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    instr_in  = '0;
    pc4_in    = '0;
    kernel_in = 1'b0;
    irq       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #3;
    chk_out("rst", 1'b0, 32'h0, 32'h80000004, 1'b0);
    chk("rst.ir", 32'(in_ready), 32'd1);
    tick();
    tick();
    reset = 1'b0;

    // Streaming with out_ready held high
    drive(1'b1, 32'h11, 32'h4);  tick(); chk_out("s1", 1'b1, 32'h11, 32'h4, 1'b0);
    drive(1'b1, 32'h22, 32'h8);  tick(); chk_out("s2", 1'b1, 32'h22, 32'h8, 1'b0);
    drive(1'b1, 32'h33, 32'hC);  tick(); chk_out("s3", 1'b1, 32'h33, 32'hC, 1'b0);
    drive(1'b0, 32'h0, 32'h0);   tick(); chk("s4.ov", 32'(out_valid), 32'd0);

    // Back-pressure: A in main, B in skid, C held by fetch
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 32'h10); tick(); chk("bp1.ir", 32'(in_ready), 32'd1);
    drive(1'b1, 32'hB, 32'h14); tick(); chk("bp2.ir", 32'(in_ready), 32'd0);
    drive(1'b1, 32'hC, 32'h18); tick();
    chk_out("bp3", 1'b1, 32'hA, 32'h10, 1'b0);
    chk("bp3.ir", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick(); chk_out("bp4", 1'b1, 32'hB, 32'h14, 1'b0); chk("bp4.ir", 32'(in_ready), 32'd1);
    tick(); chk_out("bp5", 1'b1, 32'hC, 32'h18, 1'b0);
    drive(1'b0, 32'h0, 32'h0);
    tick(); chk("bp6.ov", 32'(out_valid), 32'd0);

    // Flush with accept after skid has drained into main
    out_ready = 1'b0;
    drive(1'b1, 32'h50, 32'h20); tick();
    drive(1'b1, 32'h60, 32'h24); tick();
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);   tick();
    chk_out("fa0", 1'b1, 32'h60, 32'h24, 1'b0);
    out_ready = 1'b0;
    flush = 1'b1;
    drive(1'b1, 32'h1234, 32'h40); tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk_out("fa1", 1'b1, 32'h0, 32'h40, 1'b1);
    chk("fa1.ir", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick(); chk("fa2.ov", 32'(out_valid), 32'd0);

    // Flush with skid full: nothing accepted, both entries dropped
    out_ready = 1'b0;
    drive(1'b1, 32'h70, 32'h50); tick();
    drive(1'b1, 32'h74, 32'h54); tick();
    flush = 1'b1;
    drive(1'b1, 32'h78, 32'h58); tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fs.ov", 32'(out_valid), 32'd0);
    chk("fs.ir", 32'(in_ready), 32'd1);
    chk("fs.fl", 32'(flushed_out), 32'd0);

    // Flush without accept, main only
    drive(1'b1, 32'h80, 32'h60); tick();
    chk("fn0.ov", 32'(out_valid), 32'd1);
    flush = 1'b1;
    drive(1'b0, 32'h0, 32'h0);   tick();
    flush = 1'b0;
    chk("fn1.ov", 32'(out_valid), 32'd0);
    chk("fn1.ir", 32'(in_ready), 32'd1);

    // IRQ forcing of the kernel bit
    out_ready = 1'b1;
    kernel_in = 1'b0; irq = 1'b1;
    drive(1'b1, 32'h99, 32'h100); tick();
    chk("irq1.pc4", pc4_out, 32'h80000100);
    kernel_in = 1'b1;
    drive(1'b1, 32'h9A, 32'h100); tick();
    chk("irq2.pc4", pc4_out, 32'h00000100);
    kernel_in = 1'b0; irq = 1'b0;
    drive(1'b0, 32'h0, 32'h0); tick();

    // IRQ pulse while back-pressured is remembered
    out_ready = 1'b0;
    drive(1'b1, 32'hB1, 32'h300); tick();
    drive(1'b1, 32'hB2, 32'h304); tick();
    drive(1'b0, 32'h0, 32'h0);
    irq = 1'b1; tick();
    irq = 1'b0;
    chk("irqp0.pc4", pc4_out, 32'h300);
    out_ready = 1'b1; tick();
    chk("irqp1.pc4", pc4_out, 32'h304);
    drive(1'b1, 32'hB3, 32'h200); tick();
    chk_out("irqp2", 1'b1, 32'hB3, 32'h80000200, 1'b0);
    drive(1'b1, 32'hB4, 32'h204); tick();
    chk("irqp3.pc4", pc4_out, 32'h204);
    drive(1'b0, 32'h0, 32'h0); tick();

    // Asynchronous reset mid-cycle with the skid full
    out_ready = 1'b0;
    drive(1'b1, 32'hC1, 32'h400); tick();
    drive(1'b1, 32'hC2, 32'h404); tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("ar0.ir", 32'(in_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("ar1.ov", 32'(out_valid), 32'd0);
    chk("ar1.ir", 32'(in_ready), 32'd1);
    chk("ar1.pc4", pc4_out, 32'h80000004);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'hD1, 32'h8); tick();
    chk_out("ar2", 1'b1, 32'hD1, 32'h8, 1'b0);
    drive(1'b0, 32'h0, 32'h0); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
